// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the shared-ALU sequencer: ALU op-codes, FSM states,
// and the width of the settle counter.
package alu_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] XOR  = 3'd2;
  localparam logic [2:0] SLT  = 3'd3;
  localparam logic [2:0] AND  = 3'd4;
  localparam logic [2:0] NAND = 3'd5;
  localparam logic [2:0] NOR  = 3'd6;
  localparam logic [2:0] OR   = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bundles both requester channels, the ALU datapath connection and the response bus.
// The "slave" modport is the controller's view; "master" is the surrounding logic.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;

  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_carryout;
  logic             resp_zero;
  logic             resp_overflow;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carryout, alu_zero, alu_overflow,
    output resp_valid, resp_id, resp_result, resp_carryout, resp_zero, resp_overflow,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carryout, alu_zero, alu_overflow,
    input  resp_valid, resp_id, resp_result, resp_carryout, resp_zero, resp_overflow,
    input  busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one slow combinational ALU between two requesters: latches an op, holds it
// for SETTLE_CYCLES so the gate ripple completes, then captures and tags the result.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int OPW           = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_carryout_q, resp_carryout_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_overflow_q, resp_overflow_d;
  logic [1:0]       grant;

  // Arbitration only runs in IDLE, so readies drop to zero whenever the ALU is occupied.
  rr_arbiter2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .enable     (state_q == IDLE),
    .grant      (grant)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_op_d        = alu_op_q;
    resp_valid_d    = 1'b0;
    resp_id_d       = resp_id_q;
    resp_result_d   = resp_result_q;
    resp_carryout_d = resp_carryout_q;
    resp_zero_d     = resp_zero_q;
    resp_overflow_d = resp_overflow_q;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          alu_a_d    = grant[1] ? bus.req1_a  : bus.req0_a;
          alu_b_d    = grant[1] ? bus.req1_b  : bus.req0_b;
          alu_op_d   = grant[1] ? bus.req1_op : bus.req0_op;
          grant_id_d = grant[1];
          cnt_d      = CNT_LOAD;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        resp_result_d   = bus.alu_result;
        resp_carryout_d = bus.alu_carryout;
        resp_zero_d     = bus.alu_zero;
        resp_overflow_d = bus.alu_overflow;
        resp_id_d       = grant_id_q;
        resp_valid_d    = 1'b1;
        last_grant_d    = grant_id_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      grant_id_q      <= 1'b0;
      last_grant_q    <= 1'b1;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_op_q        <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_result_q   <= '0;
      resp_carryout_q <= 1'b0;
      resp_zero_q     <= 1'b0;
      resp_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_op_q        <= alu_op_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_result_q   <= resp_result_d;
      resp_carryout_q <= resp_carryout_d;
      resp_zero_q     <= resp_zero_d;
      resp_overflow_q <= resp_overflow_d;
    end
  end

  assign bus.req0_ready    = grant[0];
  assign bus.req1_ready    = grant[1];
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_result   = resp_result_q;
  assign bus.resp_carryout = resp_carryout_q;
  assign bus.resp_zero     = resp_zero_q;
  assign bus.resp_overflow = resp_overflow_q;
  assign bus.busy          = (state_q == SETTLE) || (state_q == CAPTURE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a vector table of single ops plus hand-written
// sequences for fairness, backpressure, reset abort and the one-cycle settle window.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(WIDTH), .OPW(OPW)) bus4 ();
  alu_share_ctrl_if #(.WIDTH(WIDTH), .OPW(OPW)) bus1 ();

  alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // Behavioural stand-in for the structural ALU.
  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        v;
  } alu_out_t;

  function automatic alu_out_t aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    alu_out_t    o;
    o = '0;
    s = '0;
    case (op)
      ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      SUB: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      XOR:     o.r = a ^ b;
      SLT:     o.r = {31'd0, ($signed(a) < $signed(b))};
      AND:     o.r = a & b;
      NAND:    o.r = ~(a & b);
      NOR:     o.r = ~(a | b);
      default: o.r = a | b;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  alu_out_t alu4_o, alu1_o;
  always_comb alu4_o = aluModel(bus4.alu_op, bus4.alu_a, bus4.alu_b);
  always_comb alu1_o = aluModel(bus1.alu_op, bus1.alu_a, bus1.alu_b);
  assign bus4.alu_result   = alu4_o.r;
  assign bus4.alu_carryout = alu4_o.c;
  assign bus4.alu_zero     = alu4_o.z;
  assign bus4.alu_overflow = alu4_o.v;
  assign bus1.alu_result   = alu1_o.r;
  assign bus1.alu_carryout = alu1_o.c;
  assign bus1.alu_zero     = alu1_o.z;
  assign bus1.alu_overflow = alu1_o.v;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs[10];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic valid, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus4.req1_valid = valid;
      bus4.req1_op    = op;
      bus4.req1_a     = a;
      bus4.req1_b     = b;
    end else begin
      bus4.req0_valid = valid;
      bus4.req0_op    = op;
      bus4.req0_a     = a;
      bus4.req0_b     = b;
    end
  endtask

  function automatic logic readyOf(input logic id);
    return id ? bus4.req1_ready : bus4.req0_ready;
  endfunction

  // Waits for the response of an op accepted at the previous edge, checking that the
  // operands seen by the ALU stay put; optionally scrambles the requester inputs meanwhile.
  task automatic waitResp4(input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input bit scramble, output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus4.resp_valid) begin
        lat = k;
        break;
      end
      checkOutput("alu_a_stable", bus4.alu_a, exp_a);
      checkOutput("alu_b_stable", bus4.alu_b, exp_b);
      if (scramble) begin
        bus4.req0_a = $urandom;
        bus4.req0_b = $urandom;
        bus4.req1_a = $urandom;
        bus4.req1_b = $urandom;
      end
    end
    if (lat < 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL resp_timeout: no resp_valid within 30 cycles, required one");
    end
  endtask

  initial begin
    int lat;
    int idle_run;
    int both_hi;
    int gaps_bad;
    int pulses;
    logic grants[$];

    vecs[0] = '{1'b0, OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, AND,  32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, SUB,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    bus1.req0_valid = 1'b0; bus1.req0_op = '0; bus1.req0_a = '0; bus1.req0_b = '0;
    bus1.req1_valid = 1'b0; bus1.req1_op = '0; bus1.req1_a = '0; bus1.req1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid",  32'(bus4.resp_valid), 32'd0);
    checkOutput("rst_busy",        32'(bus4.busy), 32'd0);
    checkOutput("rst_alu_a",       bus4.alu_a, 32'd0);
    checkOutput("rst_alu_op",      32'(bus4.alu_op), 32'd0);
    checkOutput("rst_resp_result", bus4.resp_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-requester vectors; operands change right after the transfer edge.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].id, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      checkOutput($sformatf("v%0d_ready", i),       32'(readyOf(vecs[i].id)), 32'd1);
      checkOutput($sformatf("v%0d_other_ready", i), 32'(readyOf(!vecs[i].id)), 32'd0);
      @(posedge clk); #1;
      applyStimulus(vecs[i].id, 1'b0, vecs[i].op, 32'hDEAD_BEEF, 32'h1234_5678);
      checkOutput($sformatf("v%0d_busy", i),   32'(bus4.busy), 32'd1);
      checkOutput($sformatf("v%0d_alu_op", i), 32'(bus4.alu_op), 32'(vecs[i].op));
      waitResp4(vecs[i].a, vecs[i].b, 1'b1, lat);
      checkOutput($sformatf("v%0d_latency", i),  32'(lat), 32'd5);
      checkOutput($sformatf("v%0d_resp_id", i),  32'(bus4.resp_id), 32'(vecs[i].id));
      checkOutput($sformatf("v%0d_result", i),   bus4.resp_result, vecs[i].r);
      checkOutput($sformatf("v%0d_carry", i),    32'(bus4.resp_carryout), 32'(vecs[i].c));
      checkOutput($sformatf("v%0d_zero", i),     32'(bus4.resp_zero), 32'(vecs[i].z));
      checkOutput($sformatf("v%0d_overflow", i), 32'(bus4.resp_overflow), 32'(vecs[i].v));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_pulse_end", i),   32'(bus4.resp_valid), 32'd0);
      checkOutput($sformatf("v%0d_result_hold", i), bus4.resp_result, vecs[i].r);
    end

    // Tie fairness: last winner was requester 1, so grants run 0,1,0,1,...
    idle_run = 0; both_hi = 0; gaps_bad = 0;
    applyStimulus(1'b0, 1'b1, ADD, 32'd1, 32'd1);
    applyStimulus(1'b1, 1'b1, OR,  32'd2, 32'd4);
    #1;
    for (int cyc = 0; cyc < 120 && grants.size() < 8; cyc++) begin
      if (bus4.req0_ready && bus4.req1_ready) both_hi++;
      if (!bus4.busy) idle_run++;
      else idle_run = 0;
      if (bus4.req0_ready || bus4.req1_ready) begin
        grants.push_back(bus4.req1_ready);
        if (grants.size() > 1 && idle_run != 1) gaps_bad++;
      end
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, ADD, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, OR,  32'd0, 32'd0);
    checkOutput("tie_grant_count", 32'(grants.size()), 32'd8);
    for (int i = 0; i < grants.size(); i++) begin
      checkOutput($sformatf("tie_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    end
    checkOutput("tie_both_ready", 32'(both_hi), 32'd0);
    checkOutput("tie_idle_gaps",  32'(gaps_bad), 32'd0);
    repeat (7) @(posedge clk);
    #1;

    // Backpressure: requester 1 waits out a busy window, then gets accepted.
    applyStimulus(1'b0, 1'b1, AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    #1;
    checkOutput("bp_req0_ready", 32'(bus4.req0_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, AND, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, ADD, 32'd2, 32'd3);
    #1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      checkOutput("bp_req1_ready_busy", 32'(bus4.req1_ready), 32'd0);
      @(posedge clk); #1;
      if (bus4.resp_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("bp_req0_latency", 32'(lat), 32'd5);
    checkOutput("bp_req0_result",  bus4.resp_result, 32'h0F00_0F00);
    checkOutput("bp_req1_ready_idle", 32'(bus4.req1_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, ADD, 32'd0, 32'd0);
    waitResp4(32'd2, 32'd3, 1'b0, lat);
    checkOutput("bp_req1_latency", 32'(lat), 32'd5);
    checkOutput("bp_req1_id",      32'(bus4.resp_id), 32'd1);
    checkOutput("bp_req1_result",  bus4.resp_result, 32'd5);
    @(posedge clk); #1;

    // Requester 1 withdraws before IDLE: nothing may follow the requester 0 response.
    applyStimulus(1'b0, 1'b1, XOR, 32'h0F0F_0F0F, 32'h00FF_00FF);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, XOR, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, NOR, 32'd7, 32'd8);
    @(posedge clk); @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, NOR, 32'd0, 32'd0);
    waitResp4(32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0, lat);
    checkOutput("wd_req0_result", bus4.resp_result, 32'h0FF0_0FF0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus4.resp_valid || bus4.busy) pulses++;
    end
    checkOutput("wd_no_transfer", 32'(pulses), 32'd0);
    checkOutput("wd_resp_id",     32'(bus4.resp_id), 32'd0);

    // Reset during SETTLE with counter at 2 aborts the op and restores the pointer.
    applyStimulus(1'b1, 1'b1, OR, 32'h0000_1234, 32'h8000_0000);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, OR, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_busy",        32'(bus4.busy), 32'd0);
    checkOutput("rmid_alu_a",       bus4.alu_a, 32'd0);
    checkOutput("rmid_alu_b",       bus4.alu_b, 32'd0);
    checkOutput("rmid_alu_op",      32'(bus4.alu_op), 32'd0);
    checkOutput("rmid_resp_result", bus4.resp_result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus4.resp_valid) pulses++;
    end
    checkOutput("rmid_no_resp", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 1'b1, ADD, 32'd10, 32'd20);
    applyStimulus(1'b1, 1'b1, ADD, 32'd30, 32'd40);
    #1;
    checkOutput("rmid_tie_ready0", 32'(bus4.req0_ready), 32'd1);
    checkOutput("rmid_tie_ready1", 32'(bus4.req1_ready), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, ADD, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, ADD, 32'd0, 32'd0);
    waitResp4(32'd10, 32'd20, 1'b0, lat);
    checkOutput("rmid_tie_id",     32'(bus4.resp_id), 32'd0);
    checkOutput("rmid_tie_result", bus4.resp_result, 32'd30);

    // One-cycle settle window on the second instance.
    bus1.req0_valid = 1'b1; bus1.req0_op = SUB; bus1.req0_a = 32'd5; bus1.req0_b = 32'd7;
    #1;
    checkOutput("min_ready", 32'(bus1.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus1.req0_valid = 1'b0; bus1.req0_a = 32'hCAFE_F00D; bus1.req0_b = 32'h0;
    checkOutput("min_busy", 32'(bus1.busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus1.resp_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("min_latency", 32'(lat), 32'd2);
    checkOutput("min_result",  bus1.resp_result, 32'hFFFF_FFFE);
    checkOutput("min_id",      32'(bus1.resp_id), 32'd0);
    checkOutput("min_carry",   32'(bus1.resp_carryout), 32'd0);
    checkOutput("min_idle",    32'(bus1.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
